// File: rtl/oled_spi_pkg.sv
// Shared types and default configuration for the OLED SPI byte transmitter.
// The RST_LOW/RST_WAIT states exist only when OLED_SPI_TX_RST_SEQ_EN is defined.
package oled_spi_pkg;

  localparam int unsigned CLKS_PER_HALF_BIT_DEF = 32'd4;
  localparam int unsigned RST_LOW_CYCLES_DEF    = 32'd100;
  localparam int unsigned RST_WAIT_CYCLES_DEF   = 32'd100;
  localparam int unsigned BITS_PER_BYTE         = 32'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    HOLD     = 3'd2
`ifdef OLED_SPI_TX_RST_SEQ_EN
    ,
    RST_LOW  = 3'd3,
    RST_WAIT = 3'd4
`endif
  } state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/oled_rst_seq.sv
// Display power-on sequence: holds Res low, then waits before the link may be used.
// o_Done is a single-cycle strobe on the last wait cycle.
module oled_rst_seq
  import oled_spi_pkg::*;
#(
  parameter int unsigned RST_LOW_CYCLES  = RST_LOW_CYCLES_DEF,
  parameter int unsigned RST_WAIT_CYCLES = RST_WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_Res,
  output logic o_Done
);

  localparam int unsigned CNT_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] WAIT_END  = CNT_W'(RST_WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             res_r;
  logic             res_nxt_s;
  logic             done_s;

  // Low-phase then wait-phase counting; the counter parks one past the strobe.
  always_comb begin
    cnt_nxt_s = cnt_r;
    res_nxt_s = res_r;
    done_s    = 1'b0;
    if (!res_r) begin
      if (cnt_r == LOW_LAST) begin
        res_nxt_s = 1'b1;
        cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + 1'b1;
      end
    end else begin
      done_s = (cnt_r == WAIT_LAST);
      if (cnt_r != WAIT_END) begin
        cnt_nxt_s = cnt_r + 1'b1;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end
  end

  // Sequence registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      res_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      res_r <= res_nxt_s;
    end
  end

  assign o_Res  = res_r;
  assign o_Done = done_s;

endmodule

// File: rtl/oled_spi_tx.sv
// SPI mode-0 byte transmitter for an SSD1306-style OLED (MSB first, CS framed per byte).
// Define OLED_SPI_TX_RST_SEQ_EN to include the display power-on Res sequence.
module oled_spi_tx
  import oled_spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_BIT = CLKS_PER_HALF_BIT_DEF,
  parameter int unsigned RST_LOW_CYCLES    = RST_LOW_CYCLES_DEF,
  parameter int unsigned RST_WAIT_CYCLES   = RST_WAIT_CYCLES_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [7:0] i_Data,
  input  logic       i_DC,
  input  logic       i_Valid,
  output logic       o_Ready,
  output logic       o_Busy,
  output logic       o_Res,
  output logic       o_CS1_n,
  output logic       o_DC,
  output logic       o_CS2_n,
  output logic       o_D0,
  output logic       o_D1
);

  localparam int unsigned HALF_W = cnt_width(CLKS_PER_HALF_BIT - 32'd1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 32'd1);
  localparam logic [2:0] BIT_LAST = 3'(BITS_PER_BYTE - 32'd1);

  if (CLKS_PER_HALF_BIT == 32'd0 || CLKS_PER_HALF_BIT > 32'd255 ||
      RST_LOW_CYCLES == 32'd0 || RST_WAIT_CYCLES == 32'd0) begin : g_bad_cfg
    $error("oled_spi_tx: parameter out of range");
  end

`ifdef OLED_SPI_TX_RST_SEQ_EN
  logic res_s;
  logic done_s;

  oled_rst_seq #(
    .RST_LOW_CYCLES (RST_LOW_CYCLES),
    .RST_WAIT_CYCLES(RST_WAIT_CYCLES)
  ) u_rst_seq (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .o_Res (res_s),
    .o_Done(done_s)
  );

  assign o_Res = res_s;
  localparam state_e RESET_STATE = RST_LOW;
`else
  assign o_Res = 1'b1;
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e            state_r, state_nxt_s;
  logic [HALF_W-1:0] half_r, half_nxt_s;
  logic              phase_r, phase_nxt_s;
  logic [2:0]        bit_r, bit_nxt_s;
  logic [7:0]        shift_r, shift_nxt_s;
  logic              dc_r, dc_nxt_s;
  logic              cs_n_r, cs_n_nxt_s;
  logic              sclk_r, sclk_nxt_s;
  logic              ready_r, ready_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              hs_s;

  assign hs_s = i_Valid && ready_r;

  // Next state and next pin values; the shifter empties on the last bit so SDIN idles low.
  always_comb begin
    state_nxt_s = state_r;
    half_nxt_s  = half_r;
    phase_nxt_s = phase_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    dc_nxt_s    = dc_r;
    cs_n_nxt_s  = cs_n_r;
    sclk_nxt_s  = 1'b0;
    case (state_r)
`ifdef OLED_SPI_TX_RST_SEQ_EN
      RST_LOW: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else if (res_s) begin
          state_nxt_s = RST_WAIT;
        end else begin
          state_nxt_s = RST_LOW;
        end
      end
      RST_WAIT: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RST_WAIT;
        end
      end
`endif
      IDLE: begin
        if (hs_s) begin
          state_nxt_s = SHIFT;
          shift_nxt_s = i_Data;
          dc_nxt_s    = i_DC;
          cs_n_nxt_s  = 1'b0;
          half_nxt_s  = {HALF_W{1'b0}};
          phase_nxt_s = 1'b0;
          bit_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = IDLE;
          cs_n_nxt_s  = 1'b1;
        end
      end
      SHIFT: begin
        sclk_nxt_s = phase_r;
        if (half_r == HALF_LAST) begin
          half_nxt_s = {HALF_W{1'b0}};
          if (!phase_r) begin
            phase_nxt_s = 1'b1;
            sclk_nxt_s  = 1'b1;
          end else begin
            phase_nxt_s = 1'b0;
            sclk_nxt_s  = 1'b0;
            shift_nxt_s = {shift_r[6:0], 1'b0};
            if (bit_r == BIT_LAST) begin
              state_nxt_s = HOLD;
            end else begin
              bit_nxt_s = bit_r + 3'd1;
            end
          end
        end else begin
          half_nxt_s = half_r + 1'b1;
        end
      end
      HOLD: begin
        if (half_r == HALF_LAST) begin
          state_nxt_s = IDLE;
          cs_n_nxt_s  = 1'b1;
          half_nxt_s  = {HALF_W{1'b0}};
        end else begin
          half_nxt_s = half_r + 1'b1;
        end
      end
      default: begin
        state_nxt_s = RESET_STATE;
        cs_n_nxt_s  = 1'b1;
      end
    endcase
    ready_nxt_s = (state_nxt_s == IDLE);
    busy_nxt_s  = (state_nxt_s != IDLE);
  end

  // State, counters and registered pin drivers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r <= RESET_STATE;
      half_r  <= {HALF_W{1'b0}};
      phase_r <= 1'b0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      dc_r    <= 1'b0;
      cs_n_r  <= 1'b1;
      sclk_r  <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      half_r  <= half_nxt_s;
      phase_r <= phase_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      dc_r    <= dc_nxt_s;
      cs_n_r  <= cs_n_nxt_s;
      sclk_r  <= sclk_nxt_s;
      ready_r <= ready_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign o_Ready = ready_r;
  assign o_Busy  = busy_r;
  assign o_CS1_n = cs_n_r;
  assign o_CS2_n = 1'b1;
  assign o_DC    = dc_r;
  assign o_D0    = sclk_r;
  assign o_D1    = shift_r[7];

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx at CLKS_PER_HALF_BIT=2; adapts to OLED_SPI_TX_RST_SEQ_EN.
module tb_oled_spi_tx;

  localparam int unsigned H = 2;
  localparam int CS_LOW_EXP = 17 * H;
`ifdef OLED_SPI_TX_RST_SEQ_EN
  localparam logic RES_IN_RST    = 1'b0;
  localparam int   READY_IDX_EXP = 199;
  localparam int   WATCH_N       = 260;
`else
  localparam logic RES_IN_RST    = 1'b1;
  localparam int   READY_IDX_EXP = 0;
  localparam int   WATCH_N       = 50;
`endif

  logic       clk, rst_n;
  logic [7:0] data;
  logic       dc, valid;
  logic       o_Ready, o_Busy, o_Res, o_CS1_n, o_DC, o_CS2_n, o_D0, o_D1;
  int         n_tests = 0;
  int         n_fail = 0;

  oled_spi_tx #(.CLKS_PER_HALF_BIT(H), .RST_LOW_CYCLES(100), .RST_WAIT_CYCLES(100)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Data(data), .i_DC(dc), .i_Valid(valid),
    .o_Ready(o_Ready), .o_Busy(o_Busy), .o_Res(o_Res), .o_CS1_n(o_CS1_n),
    .o_DC(o_DC), .o_CS2_n(o_CS2_n), .o_D0(o_D0), .o_D1(o_D1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waits for o_Ready, performs one handshake, returns at the negedge of cycle T0+1.
  task automatic handshake(input logic [7:0] d, input logic c, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (o_Ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      data = d; dc = c; valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0; data = ~d; dc = ~c;
    end
  endtask

  // Records one CS-low frame sample by sample; optionally offers a stray byte mid-frame.
  task automatic capture_byte(input int poke_at, output int cs_low, output int rises,
                              output logic [7:0] bits, output bit glitch, output logic dc0,
                              output logic d10, output logic busy0, output bit done);
    logic prev_d0, prev_d1;
    cs_low = 0; rises = 0; bits = 8'h00; glitch = 1'b0; done = 1'b0;
    prev_d0 = 1'b0; prev_d1 = 1'b0;
    dc0 = o_DC; d10 = o_D1; busy0 = o_Busy;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      if (poke_at >= 0 && n == poke_at) begin valid = 1'b1; data = 8'hFF; dc = 1'b0; end
      if (poke_at >= 0 && n == poke_at + 4) valid = 1'b0;
      if (o_CS1_n === 1'b1) begin
        done = 1'b1;
        break;
      end
      cs_low++;
      if (o_D0 === 1'b1 && prev_d0 === 1'b0) begin
        rises++;
        bits = {bits[6:0], o_D1};
      end
      if (o_D0 === 1'b1 && prev_d0 === 1'b1 && o_D1 !== prev_d1) glitch = 1'b1;
      prev_d0 = o_D0; prev_d1 = o_D1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; data = 8'h00; dc = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (o_Res !== RES_IN_RST) begin n_fail++; $display("FAIL reset_res: got %b want %b", o_Res, RES_IN_RST); end
    n_tests++; if (o_CS1_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs1: got %b want 1", o_CS1_n); end
    n_tests++; if (o_CS2_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs2: got %b want 1", o_CS2_n); end
    n_tests++; if (o_DC !== 1'b0) begin n_fail++; $display("FAIL reset_dc: got %b want 0", o_DC); end
    n_tests++; if (o_D0 !== 1'b0) begin n_fail++; $display("FAIL reset_d0: got %b want 0", o_D0); end
    n_tests++; if (o_D1 !== 1'b0) begin n_fail++; $display("FAIL reset_d1: got %b want 0", o_D1); end
    n_tests++; if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_Ready); end
    n_tests++; if (o_Busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", o_Busy); end
  endtask

`ifdef OLED_SPI_TX_RST_SEQ_EN
  task automatic test_power_up();
    int res_i, rdy_i;
    res_i = -1; rdy_i = -1;
    rst_n = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (res_i < 0 && o_Res === 1'b1) res_i = i;
      if (o_Ready === 1'b1) begin rdy_i = i; break; end
    end
    n_tests++; if (res_i != 100) begin n_fail++; $display("FAIL pwr_res_rise: got %0d want 100", res_i); end
    n_tests++; if (rdy_i != 200) begin n_fail++; $display("FAIL pwr_ready_rise: got %0d want 200", rdy_i); end
    n_tests++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL pwr_busy: got %b want 0", o_Busy); end
  endtask
`else
  task automatic test_first_ready();
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL first_ready: got %b want 1", o_Ready); end
    n_tests++; if (o_Res !== 1'b1) begin n_fail++; $display("FAIL first_res: got %b want 1", o_Res); end
    n_tests++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL first_busy: got %b want 0", o_Busy); end
  endtask
`endif

  task automatic test_single_bytes();
    logic [7:0] tv_d [2];
    logic       tv_c [2];
    int cs_low, rises;
    logic [7:0] bits;
    bit glitch, done, ok;
    logic dc0, d10, busy0;
    tv_d[0] = 8'hA5; tv_c[0] = 1'b0;
    tv_d[1] = 8'h3C; tv_c[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      handshake(tv_d[t], tv_c[t], ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL byte%0d_handshake: ready never seen", t); end
      capture_byte(-1, cs_low, rises, bits, glitch, dc0, d10, busy0, done);
      n_tests++; if (!done) begin n_fail++; $display("FAIL byte%0d_end: CS never rose", t); end
      n_tests++; if (cs_low != CS_LOW_EXP) begin n_fail++; $display("FAIL byte%0d_cs_low: got %0d want %0d", t, cs_low, CS_LOW_EXP); end
      n_tests++; if (rises != 8) begin n_fail++; $display("FAIL byte%0d_sclk_rises: got %0d want 8", t, rises); end
      n_tests++; if (bits !== tv_d[t]) begin n_fail++; $display("FAIL byte%0d_bits: got %h want %h", t, bits, tv_d[t]); end
      n_tests++; if (glitch) begin n_fail++; $display("FAIL byte%0d_sdin_stable: got change while SCLK high want none", t); end
      n_tests++; if (dc0 !== tv_c[t]) begin n_fail++; $display("FAIL byte%0d_dc_first: got %b want %b", t, dc0, tv_c[t]); end
      n_tests++; if (d10 !== tv_d[t][7]) begin n_fail++; $display("FAIL byte%0d_msb_first: got %b want %b", t, d10, tv_d[t][7]); end
      n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL byte%0d_busy: got %b want 1", t, busy0); end
      n_tests++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL byte%0d_ready_end: got %b want 1", t, o_Ready); end
      n_tests++; if (o_D1 !== 1'b0 || o_D0 !== 1'b0) begin n_fail++; $display("FAIL byte%0d_idle_pins: got d0=%b d1=%b want 0 0", t, o_D0, o_D1); end
      n_tests++; if (o_DC !== tv_c[t]) begin n_fail++; $display("FAIL byte%0d_dc_hold: got %b want %b", t, o_DC, tv_c[t]); end
      n_tests++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL byte%0d_busy_end: got %b want 0", t, o_Busy); end
    end
  endtask

  task automatic test_ignore_busy();
    int cs_low, rises, extra;
    logic [7:0] bits;
    bit glitch, done, ok;
    logic dc0, d10, busy0;
    handshake(8'h5A, 1'b1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ign_handshake: ready never seen"); end
    capture_byte(6, cs_low, rises, bits, glitch, dc0, d10, busy0, done);
    n_tests++; if (rises != 8 || bits !== 8'h5A) begin n_fail++; $display("FAIL ign_byte: got %0d bits %h want 8 bits 5a", rises, bits); end
    n_tests++; if (cs_low != CS_LOW_EXP) begin n_fail++; $display("FAIL ign_cs_low: got %0d want %0d", cs_low, CS_LOW_EXP); end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_CS1_n !== 1'b1 || o_D0 !== 1'b0) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL ign_no_second_byte: got %0d active cycles want 0", extra); end
    n_tests++; if (o_DC !== 1'b1) begin n_fail++; $display("FAIL ign_dc: got %b want 1", o_DC); end
  endtask

  task automatic test_back_to_back();
    int hs [2];
    int fall [2];
    int k, f, rises, chg_n, chg_cnt;
    logic [15:0] bits;
    logic prev_cs, prev_d0, prev_dc, dc_fall0;
    bit pend, ok, fin;
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (o_Ready === 1'b1) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_idle: ready never seen"); end
    hs[0] = -1; hs[1] = -1; fall[0] = -1; fall[1] = -1;
    k = 0; f = 0; rises = 0; chg_n = -1; chg_cnt = 0; bits = 16'h0000;
    pend = 1'b0; fin = 1'b0; dc_fall0 = 1'bx;
    prev_cs = o_CS1_n; prev_d0 = o_D0; prev_dc = o_DC;
    data = 8'h00; dc = 1'b1; valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (n > 0) @(negedge clk);
      if (pend) begin
        if (k == 1) begin data = 8'hFF; dc = 1'b0; end
        else begin valid = 1'b0; data = 8'h5A; dc = 1'b1; end
        pend = 1'b0;
      end
      if (valid && o_Ready === 1'b1) begin
        if (k < 2) hs[k] = n;
        k++; pend = 1'b1;
      end
      if (f >= 1 && o_DC !== prev_dc) begin chg_cnt++; chg_n = n; end
      if (prev_cs === 1'b1 && o_CS1_n === 1'b0) begin
        if (f == 0) dc_fall0 = o_DC;
        if (f < 2) fall[f] = n;
        f++;
      end
      if (o_D0 === 1'b1 && prev_d0 === 1'b0) begin rises++; bits = {bits[14:0], o_D1}; end
      prev_cs = o_CS1_n; prev_d0 = o_D0; prev_dc = o_DC;
      if (k >= 2 && f >= 2 && o_CS1_n === 1'b1) begin fin = 1'b1; break; end
    end
    valid = 1'b0;
    n_tests++; if (!fin) begin n_fail++; $display("FAIL b2b_done: got k=%0d f=%0d want 2 2", k, f); end
    n_tests++; if (hs[1] - hs[0] != CS_LOW_EXP + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", hs[1] - hs[0], CS_LOW_EXP + 1); end
    n_tests++; if (fall[0] - hs[0] != 1 || fall[1] - hs[1] != 1) begin n_fail++; $display("FAIL b2b_cs_fall: got %0d %0d want 1 1", fall[0] - hs[0], fall[1] - hs[1]); end
    n_tests++; if (dc_fall0 !== 1'b1) begin n_fail++; $display("FAIL b2b_dc_first: got %b want 1", dc_fall0); end
    n_tests++; if (chg_cnt != 1 || chg_n != fall[1]) begin n_fail++; $display("FAIL b2b_dc_switch: got %0d changes at %0d want 1 at %0d", chg_cnt, chg_n, fall[1]); end
    n_tests++; if (rises != 16 || bits !== 16'h00FF) begin n_fail++; $display("FAIL b2b_bits: got %0d rises %h want 16 00ff", rises, bits); end
    n_tests++; if (o_DC !== 1'b0) begin n_fail++; $display("FAIL b2b_dc_end: got %b want 0", o_DC); end
  endtask

  task automatic test_reset_mid_byte();
    int rises, extra, cs_lo, rdy_idx;
    logic prev_d0, res_first;
    bit ok, reached;
    handshake(8'hA5, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_handshake: ready never seen"); end
    rises = 0; prev_d0 = 1'b0; reached = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) @(negedge clk);
      if (o_D0 === 1'b1 && prev_d0 === 1'b0) rises++;
      prev_d0 = o_D0;
      if (rises == 5) begin reached = 1'b1; break; end
    end
    n_tests++; if (!reached) begin n_fail++; $display("FAIL mid_reach_bit3: got %0d rises want 5", rises); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (o_CS1_n !== 1'b1 || o_D0 !== 1'b0) begin n_fail++; $display("FAIL mid_async_abort: got cs=%b d0=%b want 1 0", o_CS1_n, o_D0); end
    n_tests++; if (o_Ready !== 1'b0 || o_Busy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_flags: got rdy=%b busy=%b want 0 1", o_Ready, o_Busy); end
    n_tests++; if (o_Res !== RES_IN_RST || o_D1 !== 1'b0 || o_DC !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pins: got res=%b d1=%b dc=%b want %b 0 0", o_Res, o_D1, o_DC, RES_IN_RST); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0; cs_lo = 0; rdy_idx = -1; prev_d0 = 1'b0; res_first = 1'bx;
    for (int n = 0; n < WATCH_N; n++) begin
      @(negedge clk);
      if (n == 0) res_first = o_Res;
      if (o_D0 === 1'b1 && prev_d0 === 1'b0) extra++;
      if (o_CS1_n !== 1'b1) cs_lo++;
      if (rdy_idx < 0 && o_Ready === 1'b1) rdy_idx = n;
      prev_d0 = o_D0;
    end
    n_tests++; if (res_first !== RES_IN_RST) begin n_fail++; $display("FAIL mid_restart_res: got %b want %b", res_first, RES_IN_RST); end
    n_tests++; if (rdy_idx != READY_IDX_EXP) begin n_fail++; $display("FAIL mid_ready_idx: got %0d want %0d", rdy_idx, READY_IDX_EXP); end
    n_tests++; if (extra != 0 || cs_lo != 0) begin n_fail++; $display("FAIL mid_no_resume: got %0d sclk edges %0d cs-low cycles want 0 0", extra, cs_lo); end
  endtask

  initial begin
    test_reset();
`ifdef OLED_SPI_TX_RST_SEQ_EN
    test_power_up();
`else
    test_first_ready();
`endif
    test_single_bytes();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_byte();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
